cmp_seq_ctrl: RTL
=================

// Module: cmp_seq_ctrl
// PURPOSE
//  Multi-cycle controller that sequences one WORD_W-bit subtract/compare slice over WORDS words
//  (LSW first) to compare wide operands A-B and produce difference plus NZCV flags.
//  Sits between the ALU issue logic and the flag register; valid/ready on both sides.
//  One slice is reused every cycle; the borrow chain is carried in a register between words.
// PARAMETERS
//  WORD_W  32  width of one subtract slice (bits)
//  WORDS   2   number of slices per operand (>=1); operand width = WORD_W*WORDS
// PORTS
//  i_clk     in   1               clock, all state on rising edge
//  i_rst_n   in   1               asynchronous, active-low reset
//  i_valid   in   1               request: operands and i_c_in valid
//  o_ready   out  1               controller idle, request accepted when i_valid&&o_ready
//  i_op_a    in   WORD_W*WORDS    minuend A
//  i_op_b    in   WORD_W*WORDS    subtrahend B
//  i_c_in    in   1               initial carry (1 = plain A-B, 0 = A-B-1 / with borrow)
//  o_valid   out  1               result valid, held until i_ready
//  i_ready   in   1               consumer takes result when o_valid&&i_ready
//  o_diff    out  WORD_W*WORDS    A + ~B + c_in (mod 2^(WORD_W*WORDS))
//  o_n,o_z,o_c,o_v out 1 each     negative, zero, carry(no-borrow), signed overflow
// BEHAVIOUR
//  Reset (async, i_rst_n=0): state IDLE; o_valid=0; o_diff=0; o_n/o_z/o_c/o_v=0; o_ready=1.
//  Reset mid-operation aborts immediately; partial results discarded, no o_valid.
//  o_ready = (state==IDLE), decoded from state; no acceptance in RUN or DONE (i_valid ignored).
//  States: IDLE -> RUN on accept; RUN -> RUN while idx<WORDS-1; RUN -> DONE at idx==WORDS-1;
//   DONE -> IDLE on i_ready. No back-to-back accept in DONE.
//  Accept edge: latch A,B; carry<=i_c_in; idx<=0; zacc<=1.
//  Each RUN cycle: {cout,s} = A[idx] + ~B[idx] + carry (WORD_W+1 bits); o_diff[idx]<=s;
//   carry<=cout; zacc<=zacc&(s==0); idx<=idx+1.
//  Last word (idx==WORDS-1): o_n<=s[MSB]; o_z<=zacc&(s==0); o_c<=cout;
//   o_v<=(a_msb^b_msb)&(a_msb^s[MSB]) using MSBs of top word. Enter DONE, o_valid<=1.
//  Latency: accept at edge k -> o_valid high after edge k+WORDS. WORDS=1 -> 1 cycle.
//  o_diff/flags stable while o_valid=1; o_valid stays 1 until i_ready sampled high.
//  Flags/diff retain last result in IDLE (not cleared) until next completion or reset.
//  idx width max(1,$clog2(WORDS)); no wrap beyond WORDS-1.
// STRUCTURE
//  Package alu_cmp_pkg: cmp_state_t enum {IDLE,RUN,DONE}; nzcv_t struct {n,z,c,v};
//   default WORD_W constant.
//  Sub-module sub_slice: combinational WORD_W-bit a + ~b + cin -> {cout,s}; one instance.
//  Controller: FSM, word index counter, carry/zacc registers, operand and result registers.
// TESTING (WORD_W=32, WORDS=2 unless stated; c_in=1)
//  A=0x00000001_00000000, B=0x00000000_FFFFFFFF -> diff=1, N0 Z0 C1 V0, o_valid 2 cycles after accept.
//  A=B=0x12345678_9ABCDEF0 -> diff=0, N0 Z1 C1 V0.
//  A=0, B=1 -> diff=0xFFFFFFFF_FFFFFFFF, N1 Z0 C0 V0.
//  A=0x80000000_00000000, B=1 -> diff=0x7FFFFFFF_FFFFFFFF, N0 Z0 C1 V1.
//  A=0x00000001_00000000, B=0 with i_ready low 5 cycles, i_valid pulsed during RUN/DONE
//   -> low word 0 but Z0, outputs held, extra requests ignored, one result only.
//  i_rst_n low during RUN -> all outputs 0 at once, o_ready=1 after release; next op correct.

Source files
------------

// File: rtl/alu_cmp_pkg.sv
// Shared types for the multi-word compare/subtract controller.
package alu_cmp_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } cmp_state_t;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } nzcv_t;

  localparam int unsigned WORD_W_DEF = 32;

endpackage

// File: rtl/sub_slice.sv
// One WORD_W-bit subtract slice: {cout, s} = a + ~b + cin.
module sub_slice #(
  parameter int unsigned WORD_W = 32
) (
  input  logic [WORD_W-1:0] a,
  input  logic [WORD_W-1:0] b,
  input  logic              cin,
  output logic [WORD_W-1:0] s,
  output logic              cout
);

  assign {cout, s} = {1'b0, a} + {1'b0, ~b} + {{WORD_W{1'b0}}, cin};

endmodule

// File: rtl/cmp_seq_ctrl.sv
// Sequences one subtract slice over WORDS words (LSW first) to produce A-B
// with NZCV flags; valid/ready handshakes on both request and result sides.
module cmp_seq_ctrl
  import alu_cmp_pkg::*;
#(
  parameter int unsigned WORD_W = WORD_W_DEF,
  parameter int unsigned WORDS  = 2
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_valid,
  output logic                    o_ready,
  input  logic [WORD_W*WORDS-1:0] i_op_a,
  input  logic [WORD_W*WORDS-1:0] i_op_b,
  input  logic                    i_c_in,
  output logic                    o_valid,
  input  logic                    i_ready,
  output logic [WORD_W*WORDS-1:0] o_diff,
  output logic                    o_n,
  output logic                    o_z,
  output logic                    o_c,
  output logic                    o_v
);

  localparam int unsigned OP_W  = WORD_W * WORDS;
  localparam int unsigned IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(WORDS - 1);

  cmp_state_t        state;
  logic [OP_W-1:0]   a_q;
  logic [OP_W-1:0]   b_q;
  logic [OP_W-1:0]   diff_q;
  logic              carry;
  logic              zacc;
  logic              valid_q;
  logic [IDX_W-1:0]  idx;
  nzcv_t             flags;

  logic [WORD_W-1:0] a_w;
  logic [WORD_W-1:0] b_w;
  logic [WORD_W-1:0] s;
  logic              cout;

  // Word select for the shared slice, driven by the current word index.
  always_comb begin
    a_w = '0;
    b_w = '0;
    for (int unsigned w = 0; w < WORDS; w++) begin
      if (idx == IDX_W'(w)) begin
        a_w = a_q[w*WORD_W +: WORD_W];
        b_w = b_q[w*WORD_W +: WORD_W];
      end
    end
  end

  sub_slice #(
    .WORD_W(WORD_W)
  ) u_slice (
    .a   (a_w),
    .b   (b_w),
    .cin (carry),
    .s   (s),
    .cout(cout)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state   <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      diff_q  <= '0;
      carry   <= 1'b0;
      zacc    <= 1'b0;
      valid_q <= 1'b0;
      idx     <= '0;
      flags   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (i_valid) begin
            a_q   <= i_op_a;
            b_q   <= i_op_b;
            carry <= i_c_in;
            idx   <= '0;
            zacc  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          for (int unsigned w = 0; w < WORDS; w++) begin
            if (idx == IDX_W'(w)) diff_q[w*WORD_W +: WORD_W] <= s;
          end
          carry <= cout;
          zacc  <= zacc & (s == '0);
          if (idx == LAST) begin
            // Overflow uses operand MSBs of the top word and the final slice sum.
            flags.n <= s[WORD_W-1];
            flags.z <= zacc & (s == '0);
            flags.c <= cout;
            flags.v <= (a_q[OP_W-1] ^ b_q[OP_W-1]) & (a_q[OP_W-1] ^ s[WORD_W-1]);
            valid_q <= 1'b1;
            state   <= DONE;
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end
        DONE: begin
          if (i_ready) begin
            valid_q <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign o_ready = (state == IDLE);
  assign o_valid = valid_q;
  assign o_diff  = diff_q;
  assign o_n     = flags.n;
  assign o_z     = flags.z;
  assign o_c     = flags.c;
  assign o_v     = flags.v;

endmodule
